assoc_buffer_histogram_master: RTL and testbench

- Initiator for the associative buffer's ctrl/key/data_input/data_output/valid interface.
- Accepts a stream of keys over a valid/ready handshake and maintains a per-key occurrence count inside the buffer.
- Per key: looks the key up. Issues INCR if the key is present, or LOAD with count 1 if it is absent.
- Also tracks buffer occupancy, flags overflow and saturation, and issues CLR on request.

---
 rtl/assoc_buffer_histogram_master.sv | 146 ++++++++++++++
 tb/tb_assoc_buffer_histogram_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_buffer_histogram_master.sv
// assoc_buffer_histogram_master
// Drives an associative buffer so that it holds one occurrence count per key.
// Each accepted key is looked up. A present key is incremented, and an absent key is
// loaded with count 1. Occupancy is tracked here. Sticky flags report dropped keys
// and saturated counts. A clear request empties the buffer and resets the bookkeeping.
// Optional build macro ASSOC_HIST_DROP_CNT_EN adds an 8-bit saturating drop_cnt output.
module assoc_buffer_histogram_master #(
  parameter int KEY_WIDTH   = 2,
  parameter int DATA_WIDTH  = 4,
  parameter int BUFFER_SIZE = 4,
  localparam int ENT_WIDTH  = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  input  logic                  in_valid,
  input  logic [KEY_WIDTH-1:0]  in_key,
  output logic                  in_ready,
  output logic [1:0]            buf_ctrl,
  output logic [KEY_WIDTH-1:0]  buf_key,
  output logic [DATA_WIDTH-1:0] buf_data,
  input  logic [DATA_WIDTH-1:0] buf_rdata,
  input  logic                  buf_valid,
  output logic [ENT_WIDTH-1:0]  entries,
  output logic                  overflow,
  output logic                  saturated,
  output logic                  busy
`ifdef ASSOC_HIST_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE, CLEAR} state_t;

  localparam logic [1:0] CTRL_NONE = 2'd0;
  localparam logic [1:0] CTRL_CLR  = 2'd1;
  localparam logic [1:0] CTRL_LOAD = 2'd2;
  localparam logic [1:0] CTRL_INCR = 2'd3;

  localparam logic [ENT_WIDTH-1:0] ENT_FULL = ENT_WIDTH'(BUFFER_SIZE);

  state_t state;
  state_t state_next;
  logic   clr_pending;
  logic   clear_now;
  logic   accept_key;
  logic   count_max;
  logic   table_full;

  assign in_ready   = rst && (state == IDLE) && !clr_req && !clr_pending;
  assign busy       = (state != IDLE);
  assign clear_now  = (state == IDLE) && (clr_req || clr_pending);
  assign accept_key = in_valid && in_ready;
  assign count_max  = (buf_rdata == {DATA_WIDTH{1'b1}});
  assign table_full = (entries == ENT_FULL);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode: a clear in IDLE wins over an offered key
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (clear_now)       state_next = CLEAR;
        else if (accept_key) state_next = LOOKUP;
      end
      LOOKUP:  state_next = ISSUE;
      ISSUE:   state_next = IDLE;
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Remember a clear that arrives while busy so it runs at the next IDLE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                clr_pending <= 1'b0;
    else if (state == IDLE)  clr_pending <= 1'b0;
    else if (clr_req)        clr_pending <= 1'b1;
  end

  // Buffer command, key/data and occupancy/flag bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_ctrl  <= CTRL_NONE;
      buf_key   <= '0;
      buf_data  <= '0;
      entries   <= '0;
      overflow  <= 1'b0;
      saturated <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_now)       buf_ctrl <= CTRL_CLR;
          else if (accept_key) buf_key  <= in_key;
        end
        LOOKUP: begin
          if (buf_valid) begin
            if (!count_max) begin
              buf_ctrl <= CTRL_INCR;
            end else begin
              buf_ctrl  <= CTRL_NONE;
              saturated <= 1'b1;
            end
          end else if (!table_full) begin
            buf_ctrl <= CTRL_LOAD;
            buf_data <= DATA_WIDTH'(1);
            entries  <= entries + ENT_WIDTH'(1);
          end else begin
            buf_ctrl <= CTRL_NONE;
            overflow <= 1'b1;
          end
        end
        ISSUE: begin
          buf_ctrl <= CTRL_NONE;
          buf_data <= '0;
        end
        CLEAR: begin
          buf_ctrl  <= CTRL_NONE;
          entries   <= '0;
          overflow  <= 1'b0;
          saturated <= 1'b0;
        end
        default: buf_ctrl <= CTRL_NONE;
      endcase
    end
  end

`ifdef ASSOC_HIST_DROP_CNT_EN
  // Count keys dropped for lack of space, saturating at 8'hFF
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= 8'h00;
    end else if (state == CLEAR) begin
      drop_cnt <= 8'h00;
    end else if (state == LOOKUP && !buf_valid && table_full && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_assoc_buffer_histogram_master.sv
// tb_assoc_buffer_histogram_master
// Drives keys and clears into the master and emulates the associative buffer it talks to.
// A reference histogram predicts each buffer command into a queue.
// A monitor pops that queue whenever a command appears on buf_ctrl.
module tb_assoc_buffer_histogram_master;
  localparam int KW = 2;
  localparam int DW = 4;
  localparam int BS = 3;
  localparam int EW = $clog2(BS + 1);
  localparam int NKEYS = 1 << KW;
  localparam int CMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr_req = 1'b0;
  logic          in_valid = 1'b0;
  logic [KW-1:0] in_key = '0;
  logic          in_ready;
  logic [1:0]    buf_ctrl;
  logic [KW-1:0] buf_key;
  logic [DW-1:0] buf_data;
  logic [DW-1:0] buf_rdata;
  logic          buf_valid;
  logic [EW-1:0] entries;
  logic          overflow;
  logic          saturated;
  logic          busy;
`ifdef ASSOC_HIST_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  assoc_buffer_histogram_master #(
    .KEY_WIDTH(KW), .DATA_WIDTH(DW), .BUFFER_SIZE(BS)
  ) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .in_valid(in_valid), .in_key(in_key),
    .in_ready(in_ready), .buf_ctrl(buf_ctrl), .buf_key(buf_key), .buf_data(buf_data),
    .buf_rdata(buf_rdata), .buf_valid(buf_valid), .entries(entries),
    .overflow(overflow), .saturated(saturated), .busy(busy)
`ifdef ASSOC_HIST_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Emulated associative buffer: combinational lookup, commands applied on the rising edge
  logic          mem_present [NKEYS];
  logic [DW-1:0] mem_count   [NKEYS];
  assign buf_valid = mem_present[buf_key];
  assign buf_rdata = mem_count[buf_key];

  // Buffer storage update
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NKEYS; i++) begin
        mem_present[i] <= 1'b0;
        mem_count[i]   <= '0;
      end
    end else begin
      case (buf_ctrl)
        2'd1: for (int i = 0; i < NKEYS; i++) begin
          mem_present[i] <= 1'b0;
          mem_count[i]   <= '0;
        end
        2'd2: begin
          mem_present[buf_key] <= 1'b1;
          mem_count[buf_key]   <= buf_data;
        end
        2'd3: mem_count[buf_key] <= mem_count[buf_key] + 1'b1;
        default: ;
      endcase
    end
  end

  // Reference histogram
  typedef struct {
    logic [1:0]    ctrl;
    logic [KW-1:0] key;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t exp_q[$];
  bit   ref_present [NKEYS];
  int   ref_count   [NKEYS];
  int   ref_entries = 0;
  bit   ref_overflow = 0;
  bit   ref_saturated = 0;
  int   ref_drops = 0;

  function automatic void ref_wipe();
    for (int i = 0; i < NKEYS; i++) begin
      ref_present[i] = 0;
      ref_count[i]   = 0;
    end
    ref_entries   = 0;
    ref_overflow  = 0;
    ref_saturated = 0;
    ref_drops     = 0;
  endfunction

  function automatic void predict_key(input logic [KW-1:0] k);
    cmd_t c;
    c.key  = k;
    c.data = '0;
    if (ref_present[k]) begin
      if (ref_count[k] == CMAX) begin
        ref_saturated = 1;
      end else begin
        ref_count[k]++;
        c.ctrl = 2'd3;
        exp_q.push_back(c);
      end
    end else if (ref_entries < BS) begin
      ref_present[k] = 1;
      ref_count[k]   = 1;
      ref_entries++;
      c.ctrl = 2'd2;
      c.data = DW'(1);
      exp_q.push_back(c);
    end else begin
      ref_overflow = 1;
      if (ref_drops < 255) ref_drops++;
    end
  endfunction

  function automatic void predict_clear();
    cmd_t c;
    c.ctrl = 2'd1;
    c.key  = '0;
    c.data = '0;
    exp_q.push_back(c);
    ref_wipe();
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every command on buf_ctrl must match the next predicted command
  initial begin
    cmd_t c;
    logic [1:0] prev_ctrl;
    prev_ctrl = 2'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_ctrl = 2'd0;
      end else begin
        if (prev_ctrl != 2'd0) checkOutput("cmd_one_cycle", int'(buf_ctrl), 0);
        if (buf_ctrl != 2'd0) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_cmd", int'(buf_ctrl), 0);
          end else begin
            c = exp_q.pop_front();
            checkOutput("cmd_ctrl", int'(buf_ctrl), int'(c.ctrl));
            if (c.ctrl != 2'd1) checkOutput("cmd_key", int'(buf_key), int'(c.key));
            if (c.ctrl == 2'd2) checkOutput("cmd_data", int'(buf_data), int'(c.data));
          end
        end
        prev_ctrl = buf_ctrl;
      end
    end
  end

  // Wait (bounded) at falling edges until the master is ready again
  task automatic wait_ready(output bit ok);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ok = in_ready;
    if (!ok) checkOutput("ready_timeout", 0, 1);
  endtask

  task automatic check_status();
    checkOutput("entries", int'(entries), ref_entries);
    checkOutput("overflow", int'(overflow), int'(ref_overflow));
    checkOutput("saturated", int'(saturated), int'(ref_saturated));
`ifdef ASSOC_HIST_DROP_CNT_EN
    checkOutput("drop_cnt", int'(drop_cnt), ref_drops);
`endif
  endtask

  // Offer one key, optionally raise a clear while the lookup is in flight
  task automatic applyStimulus(input logic [KW-1:0] k, input bit clr_in_lookup);
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    in_valid = 1'b1;
    in_key   = k;
    @(posedge clk);
    predict_key(k);
    @(negedge clk);
    in_valid = 1'b0;
    if (clr_in_lookup) begin
      checkOutput("busy_lookup", int'(busy), 1);
      checkOutput("ready_lookup", int'(in_ready), 0);
      clr_req = 1'b1;
      predict_clear();
      @(negedge clk);
      clr_req = 1'b0;
    end
    @(negedge clk);
    wait_ready(ok);
    if (ok) check_status();
  endtask

  // Clear and key offered together in IDLE: the clear goes first
  task automatic clear_priority(input logic [KW-1:0] k);
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    clr_req  = 1'b1;
    in_valid = 1'b1;
    in_key   = k;
    #1 checkOutput("ready_during_clr", int'(in_ready), 0);
    predict_clear();
    @(negedge clk);
    clr_req = 1'b0;
    checkOutput("busy_clear", int'(busy), 1);
    @(negedge clk);
    checkOutput("ready_after_clr", int'(in_ready), 1);
    check_status();
    @(posedge clk);
    predict_key(k);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    wait_ready(ok);
    if (ok) check_status();
  endtask

  initial begin
    bit ok;
    ref_wipe();

    // Power-on reset
    #12;
    checkOutput("rst_ctrl", int'(buf_ctrl), 0);
    checkOutput("rst_entries", int'(entries), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    checkOutput("rst_saturated", int'(saturated), 0);
    checkOutput("rst_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("ready_after_rst", int'(in_ready), 1);

    // Reset while a LOAD is on the bus: command vanishes at once
    @(negedge clk);
    wait_ready(ok);
    in_valid = 1'b1;
    in_key   = 2'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("cmd_before_reset", int'(buf_ctrl), 2);
    checkOutput("entries_before_reset", int'(entries), 1);
    rst = 1'b0;
    #1;
    checkOutput("ctrl_async_reset", int'(buf_ctrl), 0);
    checkOutput("ready_in_reset", int'(in_ready), 0);
    checkOutput("entries_async_reset", int'(entries), 0);
    ref_wipe();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;

    // New key then repeat: LOAD then INCR
    applyStimulus(2'd1, 1'b0);
    applyStimulus(2'd1, 1'b0);

    // Fill the buffer, then drop a fourth distinct key
    applyStimulus(2'd0, 1'b0);
    applyStimulus(2'd2, 1'b0);
    applyStimulus(2'd3, 1'b0);

    // Drive key 2 up to its maximum count and one step beyond
    for (int i = 0; i < CMAX; i++) applyStimulus(2'd2, 1'b0);

    // Clear priority, then a clear arriving during a lookup
    clear_priority(2'd0);
    applyStimulus(2'd1, 1'b1);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      logic [KW-1:0] k;
      k = KW'($urandom_range(0, NKEYS - 1));
      if ($urandom_range(0, 19) == 0)      applyStimulus(k, 1'b1);
      else if ($urandom_range(0, 29) == 0) clear_priority(k);
      else                                 applyStimulus(k, 1'b0);
    end

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end
endmodule
